// File: rtl/if_id_fetch_stage_if.sv
// IF/ID fetch stage bus bundle: instruction-memory request/response plus decode-side slot and control.
// Latency: none (pure wiring).
// Backpressure: Stall from decode; ImemAck paces the memory side.
interface if_id_fetch_stage_if;
  // instruction memory side
  logic [31:0] ImemAddr;
  logic        ImemReq;
  logic        ImemAck;
  logic [31:0] ImemData;
  // decode side
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic [31:0] InstrOut;
  logic [31:0] PCPlus4Out;
  logic [15:0] ImmOut;
  logic        ValidOut;

  // fetch stage drives the request and the IF/ID slot
  modport master (
    output ImemAddr, ImemReq, InstrOut, PCPlus4Out, ImmOut, ValidOut,
    input  ImemAck, ImemData, Stall, Redirect, RedirectPC
  );

  // memory / decode environment
  modport slave (
    input  ImemAddr, ImemReq, InstrOut, PCPlus4Out, ImmOut, ValidOut,
    output ImemAck, ImemData, Stall, Redirect, RedirectPC
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Instruction fetch into the IF/ID register with a one-entry skid buffer and redirect handling.
// Latency: ack cycle -> IF/ID slot on the next edge (one instruction per cycle with single-cycle memory).
// Backpressure: Stall holds the slot; one extra word lands in the skid buffer and fetching pauses until it drains.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             Clk,
  input  logic             Reset,
  if_id_fetch_stage_if.master bus
);

  // REQ: request outstanding at pc_q; FULL: skid holds a word, no request;
  // DROP: a pre-redirect request is still outstanding and its ack must be discarded.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_FULL = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;   // address of the abandoned request, held on the bus in DROP
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;

  logic        slot_consumed;
  logic        slot_free;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;

  assign slot_consumed   = valid_q & ~bus.Stall;
  assign slot_free       = ~valid_q | slot_consumed;
  assign pc_plus4        = pc_q + 32'd4;                  // wraps modulo 2^32
  assign redirect_target = bus.RedirectPC & ~32'h0000_0003;

  // Next-state and datapath selection; Redirect is evaluated first so it wins over everything else.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;

    case (state_q)
      ST_REQ: begin
        if (bus.Redirect) begin
          // any same-cycle ack is thrown away; an unacked request must be drained in DROP
          pc_d        = redirect_target;
          valid_d     = 1'b0;
          drop_addr_d = pc_q;
          state_d     = bus.ImemAck ? ST_REQ : ST_DROP;
        end else if (bus.ImemAck) begin
          pc_d = pc_plus4;
          if (slot_free) begin
            instr_d = bus.ImemData;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end else begin
            skid_instr_d = bus.ImemData;
            skid_pc4_d   = pc_plus4;
            state_d      = ST_FULL;
          end
        end else if (slot_consumed) begin
          valid_d = 1'b0;
        end
      end

      ST_FULL: begin
        if (bus.Redirect) begin
          pc_d    = redirect_target;
          valid_d = 1'b0;
          state_d = ST_REQ;
        end else if (slot_free) begin
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          state_d = ST_REQ;
        end
      end

      ST_DROP: begin
        if (bus.Redirect) begin
          // only the target moves; the old request is still owed exactly one ack
          pc_d    = redirect_target;
          valid_d = 1'b0;
          state_d = bus.ImemAck ? ST_REQ : ST_DROP;
        end else begin
          if (bus.ImemAck) begin
            state_d = ST_REQ;
          end
          if (slot_consumed) begin
            valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_REQ;
      end
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      drop_addr_q  <= RESET_PC;
      instr_q      <= 32'd0;
      pc4_q        <= 32'd0;
      valid_q      <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  // Request is suppressed while Reset is high so the abandoned fetch is not re-issued.
  always_comb begin
    bus.ImemReq  = ~Reset & ((state_q == ST_REQ) | (state_q == ST_DROP));
    bus.ImemAddr = (state_q == ST_DROP) ? drop_addr_q : pc_q;
  end

  // IF/ID slot outputs; the immediate field is a plain slice of the held instruction.
  always_comb begin
    bus.InstrOut   = instr_q;
    bus.PCPlus4Out = pc4_q;
    bus.ValidOut   = valid_q;
    bus.ImmOut     = instr_q[15:0];
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Bench for if_id_fetch_stage: directed vector table for the corner cases, then a randomized
// run against a transaction-level model (queue of fetched addresses awaiting decode).
module tb_if_id_fetch_stage;

  logic Clk = 1'b0;
  logic Reset;

  if_id_fetch_stage_if bus();

  if_id_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory contents as a pure function of the word address
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] data;
    logic        ereq;    // ImemReq expected during this cycle
    logic [31:0] eaddr;   // ImemAddr expected when ereq
    logic        evld;    // slot after the edge
    logic [31:0] einstr;
    logic [31:0] epc4;
  } vec_t;

  localparam int NV = 28;
  vec_t tbl [NV];

  logic [31:0] q[$];
  logic [31:0] exp_fetch;
  logic        drop_pend;
  logic        prev_req, prev_ack;
  logic [31:0] prev_addr;
  int          consumed;

  initial begin
    //         rst  stl  rdr  rpc            ack  data           req  addr           vld  instr          pc4
    tbl[0]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0};
    tbl[1]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h2001_0005,1'b1,32'h0,        1'b1,32'h2001_0005,32'h4};
    tbl[2]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h2002_FFFF,1'b1,32'h4,        1'b1,32'h2002_FFFF,32'h8};
    tbl[3]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hA000_0003,1'b1,32'h8,        1'b1,32'h2002_FFFF,32'h8};
    tbl[4]  = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'hBAD0_BAD0,1'b0,32'h0,        1'b1,32'h2002_FFFF,32'h8};
    tbl[5]  = '{1'b0,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h2002_FFFF,32'h8};
    tbl[6]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b1,32'hA000_0003,32'hC};
    tbl[7]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hA000_0004,1'b1,32'hC,        1'b1,32'hA000_0004,32'h10};
    tbl[8]  = '{1'b0,1'b0,1'b1,32'h103,      1'b1,32'hDEAD_BEEF,1'b1,32'h10,       1'b0,32'hA000_0004,32'h10};
    tbl[9]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h100,      1'b0,32'hA000_0004,32'h10};
    tbl[10] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h1111_0000,1'b1,32'h100,      1'b1,32'h1111_0000,32'h104};
    tbl[11] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h104,      1'b0,32'h1111_0000,32'h104};
    tbl[12] = '{1'b0,1'b0,1'b1,32'h40,       1'b0,32'h0,        1'b1,32'h104,      1'b0,32'h1111_0000,32'h104};
    tbl[13] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hBADB_AD00,1'b1,32'h104,      1'b0,32'h1111_0000,32'h104};
    tbl[14] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h40,       1'b0,32'h1111_0000,32'h104};
    tbl[15] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h4040_4040,1'b1,32'h40,       1'b1,32'h4040_4040,32'h44};
    tbl[16] = '{1'b0,1'b0,1'b1,32'hFFFF_FFFE,1'b1,32'hBAD0_0001,1'b1,32'h44,       1'b0,32'h4040_4040,32'h44};
    tbl[17] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hFC00_00FC,1'b1,32'hFFFF_FFFC,1'b1,32'hFC00_00FC,32'h0};
    tbl[18] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h0000_0123,1'b1,32'h0,        1'b1,32'hFC00_00FC,32'h0};
    tbl[19] = '{1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0};
    tbl[20] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0};
    tbl[21] = '{1'b0,1'b0,1'b1,32'h200,      1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0};
    tbl[22] = '{1'b0,1'b0,1'b1,32'h300,      1'b0,32'h0,        1'b1,32'h0,        1'b0,32'h0,        32'h0};
    tbl[23] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'hBAD0_0002,1'b1,32'h0,        1'b0,32'h0,        32'h0};
    tbl[24] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h3300_0000,1'b1,32'h300,      1'b1,32'h3300_0000,32'h304};
    tbl[25] = '{1'b0,1'b1,1'b0,32'h0,        1'b1,32'h3300_0001,1'b1,32'h304,      1'b1,32'h3300_0000,32'h304};
    tbl[26] = '{1'b0,1'b1,1'b1,32'h500,      1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h3300_0000,32'h304};
    tbl[27] = '{1'b0,1'b0,1'b0,32'h0,        1'b1,32'h5500_0000,1'b1,32'h500,      1'b1,32'h5500_0000,32'h504};

    Reset          = 1'b1;
    bus.Stall      = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'h0;
    bus.ImemAck    = 1'b0;
    bus.ImemData   = 32'h0;

    // directed table
    for (int i = 0; i < NV; i++) begin
      @(negedge Clk);
      Reset          = tbl[i].rst;
      bus.Stall      = tbl[i].stall;
      bus.Redirect   = tbl[i].redir;
      bus.RedirectPC = tbl[i].rpc;
      bus.ImemAck    = tbl[i].ack;
      bus.ImemData   = tbl[i].data;
      #1;
      check($sformatf("v%0d ImemReq", i), {31'd0, bus.ImemReq}, {31'd0, tbl[i].ereq});
      if (tbl[i].ereq) check($sformatf("v%0d ImemAddr", i), bus.ImemAddr, tbl[i].eaddr);
      @(posedge Clk);
      #1;
      check($sformatf("v%0d ValidOut", i), {31'd0, bus.ValidOut}, {31'd0, tbl[i].evld});
      check($sformatf("v%0d InstrOut", i), bus.InstrOut, tbl[i].einstr);
      check($sformatf("v%0d PCPlus4Out", i), bus.PCPlus4Out, tbl[i].epc4);
      check($sformatf("v%0d ImmOut", i), {16'd0, bus.ImmOut}, {16'd0, tbl[i].einstr[15:0]});
    end

    // randomized run against the transaction model
    @(negedge Clk);
    Reset        = 1'b1;
    bus.Stall    = 1'b0;
    bus.Redirect = 1'b0;
    bus.ImemAck  = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    q.delete();
    exp_fetch = 32'h0000_0000;
    drop_pend = 1'b0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'h0;
    consumed  = 0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        stall, redir, ack;
      logic [31:0] rpc;

      // outputs reflect the state after the last edge
      check("rnd ValidOut", {31'd0, bus.ValidOut}, {31'd0, (q.size() != 0)});
      check("rnd ImemReq", {31'd0, bus.ImemReq}, {31'd0, (q.size() < 2)});
      check("rnd ImmOut", {16'd0, bus.ImmOut}, {16'd0, bus.InstrOut[15:0]});
      if (prev_req && !prev_ack) check("rnd ImemAddr hold", bus.ImemAddr, prev_addr);

      stall = ($urandom_range(0, 99) < 30);
      redir = ($urandom_range(0, 99) < 5);
      rpc   = ($urandom_range(0, 1) == 1) ? $urandom : (32'hFFFF_FFF0 + {28'd0, 4'($urandom_range(0, 15))});
      ack   = bus.ImemReq && ($urandom_range(0, 99) < 60);

      bus.Stall      = stall;
      bus.Redirect   = redir;
      bus.RedirectPC = rpc;
      bus.ImemAck    = ack;
      bus.ImemData   = word_at(bus.ImemAddr);

      if (redir) begin
        q.delete();
        drop_pend = bus.ImemReq && !ack;
        exp_fetch = rpc & ~32'h3;
      end else begin
        if (bus.ValidOut && !stall && q.size() != 0) begin
          check("rnd InstrOut", bus.InstrOut, word_at(q[0]));
          check("rnd PCPlus4Out", bus.PCPlus4Out, q[0] + 32'd4);
          void'(q.pop_front());
          consumed++;
        end
        if (bus.ImemReq && ack) begin
          if (drop_pend) begin
            drop_pend = 1'b0;
          end else begin
            check("rnd fetch addr", bus.ImemAddr, exp_fetch);
            q.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
          end
        end
      end

      prev_req  = bus.ImemReq;
      prev_ack  = ack;
      prev_addr = bus.ImemAddr;
      @(negedge Clk);
    end

    check("rnd progress", {31'd0, (consumed > 100)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
